pwm_dec: RTL and testbench

PWM decoder that recovers the signed 12-bit duty command from a PWM/DIR pin pair. It is the receive side of the motor-drive path: it sits in the motor/plant model and in the bench monitor, watching `PWML`/`DIRL` or `PWMR`/`DIRR`. It measures high time per 2048-clock PWM frame, applies the direction sign and presents the result with a one-cycle valid strobe. It flags frames that do not match the PWM11 frame format.

---
 rtl/pwm_pkg.sv | 11 +
 rtl/pwm_edge_det.sv | 58 +++++
 rtl/pwm_dec.sv | 125 ++++++++++++
 tb/tb_pwm_dec.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared PWM11 frame constants and types for the motor-drive PWM encode/decode path.
package pwm_pkg;

   localparam int PWM_PRD   = 2048;
   localparam int PWM_MAG_W = 11;

   typedef enum logic [1:0] {IDLE, HIGH, LOW} pwm_dec_state_t;

   typedef logic signed [11:0] duty_t;

endpackage

// File: rtl/pwm_edge_det.sv
// Pin capture for pwm_dec: single capture flop, or a 2-flop synchronizer when
// PWM_DEC_SYNC_EN is defined. Produces captured pins and the PWM rising-edge pulse.
module pwm_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic pwm_i,
   input  logic dir_i,
   output logic pwm_s_o,
   output logic dir_s_o,
   output logic rise_o
);

   logic pwm_s_q;
   logic dir_s_q;
   logic pwm_d_q;

`ifdef PWM_DEC_SYNC_EN
   logic pwm_m_q;
   logic dir_m_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_m_q <= 1'b0;
         dir_m_q <= 1'b0;
         pwm_s_q <= 1'b0;
         dir_s_q <= 1'b0;
      end else begin
         pwm_m_q <= pwm_i;
         dir_m_q <= dir_i;
         pwm_s_q <= pwm_m_q;
         dir_s_q <= dir_m_q;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_s_q <= 1'b0;
         dir_s_q <= 1'b0;
      end else begin
         pwm_s_q <= pwm_i;
         dir_s_q <= dir_i;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_d_q <= 1'b0;
      end else begin
         pwm_d_q <= pwm_s_q;
      end
   end

   assign pwm_s_o = pwm_s_q;
   assign dir_s_o = dir_s_q;
   assign rise_o  = pwm_s_q & ~pwm_d_q;

endmodule

// File: rtl/pwm_dec.sv
// PWM/DIR decoder: measures high time per 2^PRD_W-clock frame and emits a signed duty
// with vld/err strobes. Define PWM_DEC_SYNC_EN to synchronize asynchronous pins.
module pwm_dec
   import pwm_pkg::*;
#(
   parameter int PRD_W = PWM_MAG_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 PWM,
   input  logic                 DIR,
   output logic signed [PRD_W:0] duty,
   output logic                 vld,
   output logic                 err
);

   localparam int               CNT_W     = PRD_W + 1;
   localparam logic [CNT_W-1:0] FRAME_LEN = {1'b1, {PRD_W{1'b0}}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [PRD_W-1:0] HI_ONE    = PRD_W'(1);
   localparam logic [PRD_W-1:0] HI_MAX    = '1;

   logic                    pwm_s;
   logic                    dir_s;
   logic                    rise;

   pwm_dec_state_t          state_q;
   logic [CNT_W-1:0]        prd_cnt_q;
   logic [PRD_W-1:0]        hi_cnt_q;
   logic                    dir_l_q;
   logic signed [CNT_W-1:0] duty_q;
   logic                    vld_q;
   logic                    err_q;
   logic [CNT_W-1:0]        mag;

   pwm_edge_det u_edge_det (
      .clk     (clk),
      .rst_n   (rst_n),
      .pwm_i   (PWM),
      .dir_i   (DIR),
      .pwm_s_o (pwm_s),
      .dir_s_o (dir_s),
      .rise_o  (rise)
   );

   assign mag = {1'b0, hi_cnt_q};

   // NOTE: state and outputs are flops, so every assignment here is non-blocking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         prd_cnt_q <= '0;
         hi_cnt_q  <= '0;
         dir_l_q   <= 1'b0;
         duty_q    <= '0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         vld_q <= 1'b0;
         err_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               // While the pin sits high the idle timeout is held off.
               if (rise) begin
                  state_q   <= HIGH;
                  prd_cnt_q <= CNT_ONE;
                  hi_cnt_q  <= HI_ONE;
                  dir_l_q   <= dir_s;
               end else if (pwm_s) begin
                  prd_cnt_q <= '0;
               end else if (prd_cnt_q == FRAME_LEN) begin
                  vld_q     <= 1'b1;
                  duty_q    <= '0;
                  prd_cnt_q <= CNT_ONE;
               end else begin
                  prd_cnt_q <= prd_cnt_q + CNT_ONE;
               end
            end
            HIGH: begin
               if (!pwm_s) begin
                  state_q   <= LOW;
                  prd_cnt_q <= prd_cnt_q + CNT_ONE;
               end else if (hi_cnt_q == HI_MAX) begin
                  err_q     <= 1'b1;
                  state_q   <= IDLE;
                  prd_cnt_q <= '0;
               end else begin
                  hi_cnt_q  <= hi_cnt_q + HI_ONE;
                  prd_cnt_q <= prd_cnt_q + CNT_ONE;
               end
            end
            LOW: begin
               if (rise) begin
                  if (prd_cnt_q == FRAME_LEN) begin
                     vld_q  <= 1'b1;
                     duty_q <= dir_l_q ? -$signed(mag) : $signed(mag);
                  end else begin
                     err_q <= 1'b1;
                  end
                  state_q   <= HIGH;
                  prd_cnt_q <= CNT_ONE;
                  hi_cnt_q  <= HI_ONE;
                  dir_l_q   <= dir_s;
               end else if (prd_cnt_q == FRAME_LEN) begin
                  // Missing rise: the timeout cycle stands in for it, keeping the 2048 cadence.
                  vld_q     <= 1'b1;
                  duty_q    <= '0;
                  prd_cnt_q <= CNT_ONE;
                  hi_cnt_q  <= '0;
               end else begin
                  prd_cnt_q <= prd_cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign duty = duty_q;
   assign vld  = vld_q;
   assign err  = err_q;

endmodule

// File: tb/tb_pwm_dec.sv
// Scoreboard bench for pwm_dec: expected strobes are queued as PWM frames are driven
// and popped by a monitor on each vld/err.
module tb_pwm_dec;
   import pwm_pkg::*;

`ifdef PWM_DEC_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   localparam logic [1:0] EV_VLD = 2'b10;
   localparam logic [1:0] EV_ERR = 2'b01;

   typedef struct {
      logic [1:0] kind;
      int         duty;
   } exp_t;

   logic  clk   = 1'b0;
   logic  rst_n = 1'b0;
   logic  pwm   = 1'b0;
   logic  dir   = 1'b0;
   duty_t duty;
   logic  vld;
   logic  err;

   exp_t sb[$];
   int   vld_log[$];
   int   cyc          = 0;
   int   n_checks     = 0;
   int   n_fails      = 0;
   bit   gap_en       = 1'b0;
   bit   prev_valid   = 1'b0;
   int   prev_vld_cyc = 0;
   int   rise_cyc     = 0;
   int   idx;
   int   l1_rise;

   pwm_dec #(.PRD_W(PWM_MAG_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .PWM   (pwm),
      .DIR   (dir),
      .duty  (duty),
      .vld   (vld),
      .err   (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int want);
      n_checks++;
      if (obs !== want) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, want, cyc);
      end
   endtask

   task automatic sb_push(input logic [1:0] kind, input int d);
      exp_t e;
      e.kind = kind;
      e.duty = d;
      sb.push_back(e);
   endtask

   task automatic hold(input bit p, input bit d, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         pwm = p;
         dir = d;
      end
   endtask

   // One PWM frame: high for hi cycles out of len; DIR switches from d0 to d1 at cycle sw.
   task automatic frame(input int hi, input int len, input bit d0, input bit d1, input int sw);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (i == 0) rise_cyc = cyc;
         pwm = (i < hi);
         dir = (i < sw) ? d0 : d1;
      end
   endtask

   always @(negedge clk) begin
      if (vld || err) begin
         exp_t e;
         if (sb.size() > 0) begin
            e = sb.pop_front();
         end else begin
            e.kind = 2'b00;
            e.duty = 0;
         end
         check("evt_kind", int'({vld, err}), int'(e.kind));
         check("evt_duty", int'(duty), e.duty);
         if (vld) begin
            if (gap_en && prev_valid) check("vld_period", cyc - prev_vld_cyc, PWM_PRD);
            prev_valid   = 1'b1;
            prev_vld_cyc = cyc;
            vld_log.push_back(cyc);
         end
      end
   end

   initial begin
      repeat (4) @(negedge clk);
      check("rst_duty", int'(duty), 0);
      check("rst_vld", int'(vld), 0);
      check("rst_err", int'(err), 0);

      // Pin held low from reset: two zero-duty strobes, 2048 apart.
      gap_en = 1'b1;
      sb_push(EV_VLD, 0);
      sb_push(EV_VLD, 0);
      @(negedge clk);
      rst_n = 1'b1;
      hold(1'b0, 1'b0, 5000);
      check("idle_zero_cnt", vld_log.size(), 2);
      check("sb_drain_idle", sb.size(), 0);

      // Steady +1000, then -2047 frames; each rise closes the previous frame.
      prev_valid = 1'b0;
      idx = vld_log.size();
      for (int i = 0; i < 4; i++) sb_push(EV_VLD, 1000);
      for (int i = 0; i < 5; i++) frame(1000, 2048, 1'b0, 1'b0, 2048);
      sb_push(EV_VLD, 1000);
      sb_push(EV_VLD, -2047);
      sb_push(EV_VLD, -2047);
      for (int i = 0; i < 3; i++) frame(2047, 2048, 1'b1, 1'b1, 2048);

      // Stuck high: the opening rise closes the last -2047 frame, then one err.
      gap_en = 1'b0;
      sb_push(EV_VLD, -2047);
      sb_push(EV_ERR, -2047);
      hold(1'b1, 1'b0, 3000);
      hold(1'b0, 1'b0, 48);
      check("sb_drain_stuck", sb.size(), 0);
      check("steady_vld_cnt", vld_log.size() - idx, 8);

      // Early rise after 2000 clocks: err with duty held, then a proper frame gives +300.
      sb_push(EV_ERR, -2047);
      sb_push(EV_VLD, 300);
      frame(700, 2000, 1'b0, 1'b0, 2000);
      prev_valid = 1'b0;
      gap_en     = 1'b1;
      frame(300, 2048, 1'b0, 1'b0, 2048);

      // DIR toggles mid-frame: +500 for that frame, -500 for the next.
      sb_push(EV_VLD, 500);
      sb_push(EV_VLD, -500);
      frame(500, 2048, 1'b0, 1'b1, 1000);
      frame(500, 2048, 1'b1, 1'b1, 2048);
      frame(500, 1000, 1'b1, 1'b1, 2048);
      check("sb_drain_dir", sb.size(), 0);

      // Reset mid-frame: outputs clear at once; the first vld is one frame after the first rise.
      gap_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_duty", int'(duty), 0);
      check("mid_rst_vld", int'(vld), 0);
      check("mid_rst_err", int'(err), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      hold(1'b0, 1'b1, 100);
      sb_push(EV_VLD, -1234);
      sb_push(EV_VLD, -1234);
      sb_push(EV_VLD, 0);
      prev_valid = 1'b0;
      gap_en     = 1'b1;
      idx = vld_log.size();
      frame(1234, 2048, 1'b1, 1'b1, 2048);
      l1_rise = rise_cyc;
      frame(1234, 2048, 1'b1, 1'b1, 2048);
      frame(1234, 2048, 1'b1, 1'b1, 2048);
      hold(1'b0, 1'b1, 20);
      if (vld_log.size() > idx) begin
         check("rst_first_vld_lat", vld_log[idx] - l1_rise, PWM_PRD + LAT);
      end else begin
         check("rst_first_vld_seen", vld_log.size(), idx + 1);
      end
      check("sb_drain_end", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
